// File: rtl/fir_band_mac_if.sv
// Sample-queue / coefficient-ROM / result bus for fir_band_mac.
// master = queue, ROM and gain stage side; slave = the MAC.
interface fir_band_mac_if;
  logic        sequencing;
  logic [15:0] smpl_in;
  logic [15:0] coeff;
  logic [9:0]  coeff_addr;
  logic [15:0] smpl_out;
  logic        smpl_vld;
  logic        tap_err;

  modport master (
    output sequencing, smpl_in, coeff,
    input  coeff_addr, smpl_out, smpl_vld, tap_err
  );

  modport slave (
    input  sequencing, smpl_in, coeff,
    output coeff_addr, smpl_out, smpl_vld, tap_err
  );
endinterface

// File: rtl/fir_band_mac.sv
// Per-band FIR multiply-accumulate: one Q1.15 result per queue readout frame.
// Define FIR_SAT_EN to saturate smpl_out on accumulator overflow instead of wrapping.
module fir_band_mac #(
  parameter int N_TAPS = 1021,
  parameter int ACC_W  = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  fir_band_mac_if.slave bus
);

  typedef enum logic [1:0] {IDLE, PRIME, MAC, OUT} state_e;

  state_e                   state_q, state_d;
  logic                     seq_d1_q, seq_d1_d;
  logic                     seq_d2_q, seq_d2_d;
  logic                     seq_d3_q, seq_d3_d;
  logic [9:0]               coeff_addr_q, coeff_addr_d;
  logic signed [31:0]       prod_q, prod_d;
  logic signed [ACC_W-1:0]  accum_q, accum_d;
  logic [10:0]              tap_cnt_q, tap_cnt_d;
  logic [15:0]              smpl_out_q, smpl_out_d;
  logic                     smpl_vld_q, smpl_vld_d;
  logic                     tap_err_q, tap_err_d;

  logic signed [ACC_W-1:0]  prod_ext;
  logic                     first_acc;
  logic [15:0]              result;
  logic                     unused_bits;

  assign prod_ext    = ACC_W'(prod_q);
  assign first_acc   = seq_d2_q & ~seq_d3_q;
  assign unused_bits = ^{accum_q[14:0], accum_q[ACC_W-1:31]};

`ifdef FIR_SAT_EN
  always_comb begin
    result = accum_q[30:15];
    if (!((&accum_q[ACC_W-1:30]) || !(|accum_q[ACC_W-1:30])))
      result = accum_q[ACC_W-1] ? 16'h8000 : 16'h7FFF;
  end
`else
  assign result = accum_q[30:15];
`endif

  always_comb begin
    state_d      = state_q;
    seq_d1_d     = bus.sequencing;
    seq_d2_d     = seq_d1_q;
    seq_d3_d     = seq_d2_q;
    coeff_addr_d = bus.sequencing ? coeff_addr_q + 10'd1 : '0;
    prod_d       = prod_q;
    accum_d      = accum_q;
    tap_cnt_d    = tap_cnt_q;
    smpl_out_d   = smpl_out_q;
    smpl_vld_d   = 1'b0;
    tap_err_d    = 1'b0;

    if (seq_d1_q)
      prod_d = $signed({{16{bus.smpl_in[15]}}, bus.smpl_in}) *
               $signed({{16{bus.coeff[15]}}, bus.coeff});

    // First product of a frame replaces the sum, so no explicit clear cycle is needed.
    if (seq_d2_q) begin
      if (first_acc) begin
        accum_d   = prod_ext;
        tap_cnt_d = 11'd1;
      end else begin
        accum_d = accum_q + prod_ext;
        if (tap_cnt_q != '1)
          tap_cnt_d = tap_cnt_q + 11'd1;
      end
    end

    case (state_q)
      IDLE:  if (bus.sequencing) state_d = PRIME;
      PRIME: state_d = MAC;
      // seq_d1 low means this is the last seq_d2 cycle; OUT sees the final sum.
      MAC:   if (!seq_d1_q) state_d = OUT;
      OUT: begin
        smpl_out_d = result;
        smpl_vld_d = 1'b1;
        tap_err_d  = (tap_cnt_q != 11'(N_TAPS));
        state_d    = bus.sequencing ? PRIME : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      seq_d1_q     <= 1'b0;
      seq_d2_q     <= 1'b0;
      seq_d3_q     <= 1'b0;
      coeff_addr_q <= '0;
      prod_q       <= '0;
      accum_q      <= '0;
      tap_cnt_q    <= '0;
      smpl_out_q   <= '0;
      smpl_vld_q   <= 1'b0;
      tap_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      seq_d1_q     <= seq_d1_d;
      seq_d2_q     <= seq_d2_d;
      seq_d3_q     <= seq_d3_d;
      coeff_addr_q <= coeff_addr_d;
      prod_q       <= prod_d;
      accum_q      <= accum_d;
      tap_cnt_q    <= tap_cnt_d;
      smpl_out_q   <= smpl_out_d;
      smpl_vld_q   <= smpl_vld_d;
      tap_err_q    <= tap_err_d;
    end
  end

  assign bus.coeff_addr = coeff_addr_q;
  assign bus.smpl_out   = smpl_out_q;
  assign bus.smpl_vld   = smpl_vld_q;
  assign bus.tap_err    = tap_err_q;

endmodule
